write_back_arb: RTL and testbench

Parametrised writeback stage that retires results from two producers onto one register-file write port. The in-order pipeline channel comes from the memory stage. The long-latency channel comes from units such as mul/div. The block adds things a plain writeback register lacks: valid/ready handshakes on both channels, a small result queue for the long-latency channel, a starvation-free arbiter, and load-data alignment/extension. It sits between the memory stage and the register file, and feeds forwarding, hazard and trace-debug logic.

---
 rtl/wb_pkg.sv | 42 ++++
 rtl/wb_ll_fifo.sv | 49 ++++
 rtl/write_back_arb.sv | 149 ++++++++++++++
 tb/tb_write_back_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings, entry widths and load alignment for the writeback arbiter.
package wb_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    // Alignment works on a fixed wide word; callers extend/truncate to XLEN.
    localparam int WB_ALIGN_W = 64;

    // S entry: mem_load, load_size, load_unsigned, addr_lo, load_word, alu_result, rf_we, rf_dest, pc
    function automatic int wb_s_entry_w(input int xlen, input int rf_aw);
        return 1 + 2 + 1 + 2 + xlen + xlen + 1 + rf_aw + xlen;
    endfunction

    // Q entry: rf_dest, result, pc
    function automatic int wb_q_entry_w(input int xlen, input int rf_aw);
        return rf_aw + xlen + xlen;
    endfunction

    function automatic logic [WB_ALIGN_W-1:0] wb_load_align(
        input logic [WB_ALIGN_W-1:0] word,
        input logic [1:0]            size,
        input logic                  uns,
        input logic [1:0]            addr_lo
    );
        logic [31:0]           w32;
        logic [7:0]            b;
        logic [15:0]           h;
        logic [WB_ALIGN_W-1:0] r;
        w32 = word[31:0];
        b   = 8'(w32 >> {addr_lo, 3'b000});
        h   = addr_lo[1] ? w32[31:16] : w32[15:0];
        case (size)
            LS_BYTE: r = uns ? {{(WB_ALIGN_W-8){1'b0}}, b}  : {{(WB_ALIGN_W-8){b[7]}}, b};
            LS_HALF: r = uns ? {{(WB_ALIGN_W-16){1'b0}}, h} : {{(WB_ALIGN_W-16){h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Small power-of-two FIFO holding long-latency results until they retire.
module wb_ll_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [W-1:0]           din_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (PW+1)'(DEPTH));

endmodule

// File: rtl/write_back_arb.sv
// Writeback stage: retires pipeline and long-latency results onto one RF write port.
module write_back_arb
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RF_AW      = 5,
    parameter int LL_DEPTH   = 2,
    parameter int LOAD_ALIGN = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_writeback,
    input  logic                      m_valid_i,
    output logic                      m_ready_o,
    input  logic                      m_mem_load_i,
    input  logic [XLEN-1:0]           m_load_word_i,
    input  logic [1:0]                m_load_size_i,
    input  logic                      m_load_unsigned_i,
    input  logic [1:0]                m_addr_lo_i,
    input  logic [XLEN-1:0]           m_alu_result_i,
    input  logic                      m_rf_we_i,
    input  logic [RF_AW-1:0]          m_rf_dest_i,
    input  logic [XLEN-1:0]           m_pc_i,
    input  logic                      ll_valid_i,
    output logic                      ll_ready_o,
    input  logic [RF_AW-1:0]          ll_rf_dest_i,
    input  logic [XLEN-1:0]           ll_result_i,
    input  logic [XLEN-1:0]           ll_pc_i,
    output logic                      rf_we_o,
    output logic [RF_AW-1:0]          rf_dest_o,
    output logic [XLEN-1:0]           rf_wdata_o,
    output logic                      fwd_valid_o,
    output logic [RF_AW-1:0]          fwd_dest_o,
    output logic [XLEN-1:0]           fwd_data_o,
    output logic [$clog2(LL_DEPTH):0] ll_count_o,
    output logic                      debug_wb_have_inst,
    output logic [XLEN-1:0]           debug_wb_pc,
    output logic                      debug_wb_ena,
    output logic [4:0]                debug_wb_reg,
    output logic [XLEN-1:0]           debug_wb_value
);
    localparam int S_W = wb_s_entry_w(XLEN, RF_AW);
    localparam int Q_W = wb_q_entry_w(XLEN, RF_AW);

    logic           s_valid_q, s_valid_d;
    logic [S_W-1:0] s_q, s_d;

    logic             s_mem_load, s_uns, s_we;
    logic [1:0]       s_size, s_lo;
    logic [XLEN-1:0]  s_word, s_alu, s_pc;
    logic [RF_AW-1:0] s_dest;

    assign {s_mem_load, s_size, s_uns, s_lo, s_word, s_alu, s_we, s_dest, s_pc} = s_q;

    logic [Q_W-1:0]   q_head;
    logic [RF_AW-1:0] q_dest;
    logic [XLEN-1:0]  q_result, q_pc;
    logic             q_full, q_push, q_empty;

    assign {q_dest, q_result, q_pc} = q_head;

    logic grant_pipe, grant_q, accept;

    // A full queue wins outright so long-latency units cannot be starved.
    assign q_empty    = (ll_count_o == '0);
    assign grant_q    = q_full || (!s_valid_q && !q_empty);
    assign grant_pipe = !q_full && s_valid_q;

    assign m_ready_o  = !s_valid_q || grant_pipe;
    assign ll_ready_o = !q_full;
    assign q_push     = ll_valid_i && ll_ready_o;
    assign accept     = m_valid_i && m_ready_o && !flush_writeback;

    always_comb begin
        s_d       = s_q;
        s_valid_d = s_valid_q;
        if (flush_writeback) begin
            s_valid_d = 1'b0;
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_d = {m_mem_load_i, m_load_size_i, m_load_unsigned_i, m_addr_lo_i,
                   m_load_word_i, m_alu_result_i, m_rf_we_i, m_rf_dest_i, m_pc_i};
        end else if (grant_pipe) begin
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) s_valid_q <= 1'b0;
        else       s_valid_q <= s_valid_d;
    end

    always_ff @(posedge clk) begin
        s_q <= s_d;
    end

    wb_ll_fifo #(.W(Q_W), .DEPTH(LL_DEPTH)) u_ll_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (q_push),
        .din_i   ({ll_rf_dest_i, ll_result_i, ll_pc_i}),
        .pop_i   (grant_q),
        .head_o  (q_head),
        .count_o (ll_count_o),
        .full_o  (q_full)
    );

    logic [WB_ALIGN_W-1:0] align_full;
    logic [XLEN-1:0]       load_val;

    assign align_full = wb_load_align(WB_ALIGN_W'(s_word), s_size, s_uns, s_lo);
    assign load_val   = (LOAD_ALIGN != 0) ? align_full[XLEN-1:0] : s_word;

    logic             wb_we;
    logic [RF_AW-1:0] wb_dest;
    logic [XLEN-1:0]  wb_data, wb_pc;

    always_comb begin
        wb_we   = 1'b0;
        wb_dest = '0;
        wb_data = '0;
        wb_pc   = '0;
        if (grant_q) begin
            wb_we   = 1'b1;
            wb_dest = q_dest;
            wb_data = q_result;
            wb_pc   = q_pc;
        end else if (grant_pipe) begin
            wb_we   = s_we;
            wb_dest = s_dest;
            wb_data = s_mem_load ? load_val : s_alu;
            wb_pc   = s_pc;
        end
    end

    // x0 is never written, but the retirement is still traced.
    assign rf_we_o            = wb_we && (wb_dest != '0);
    assign rf_dest_o          = wb_dest;
    assign rf_wdata_o         = wb_data;
    assign fwd_valid_o        = rf_we_o;
    assign fwd_dest_o         = rf_dest_o;
    assign fwd_data_o         = rf_wdata_o;
    assign debug_wb_have_inst = grant_q || grant_pipe;
    assign debug_wb_pc        = wb_pc;
    assign debug_wb_ena       = rf_we_o;
    assign debug_wb_reg       = 5'(wb_dest);
    assign debug_wb_value     = wb_data;

endmodule

// File: tb/tb_write_back_arb.sv
// Directed bench for write_back_arb with hand-computed expectations.
module tb_write_back_arb;

    logic        clk = 1'b0;
    logic        reset, flush_writeback;
    logic        m_valid_i, m_ready_o, m_mem_load_i, m_load_unsigned_i, m_rf_we_i;
    logic [31:0] m_load_word_i, m_alu_result_i, m_pc_i;
    logic [1:0]  m_load_size_i, m_addr_lo_i;
    logic [4:0]  m_rf_dest_i;
    logic        ll_valid_i, ll_ready_o;
    logic [4:0]  ll_rf_dest_i;
    logic [31:0] ll_result_i, ll_pc_i;
    logic        rf_we_o, fwd_valid_o, debug_wb_have_inst, debug_wb_ena;
    logic [4:0]  rf_dest_o, fwd_dest_o, debug_wb_reg;
    logic [31:0] rf_wdata_o, fwd_data_o, debug_wb_pc, debug_wb_value;
    logic [1:0]  ll_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    write_back_arb dut (
        .clk(clk), .reset(reset), .flush_writeback(flush_writeback),
        .m_valid_i(m_valid_i), .m_ready_o(m_ready_o), .m_mem_load_i(m_mem_load_i),
        .m_load_word_i(m_load_word_i), .m_load_size_i(m_load_size_i),
        .m_load_unsigned_i(m_load_unsigned_i), .m_addr_lo_i(m_addr_lo_i),
        .m_alu_result_i(m_alu_result_i), .m_rf_we_i(m_rf_we_i), .m_rf_dest_i(m_rf_dest_i),
        .m_pc_i(m_pc_i), .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o),
        .ll_rf_dest_i(ll_rf_dest_i), .ll_result_i(ll_result_i), .ll_pc_i(ll_pc_i),
        .rf_we_o(rf_we_o), .rf_dest_o(rf_dest_o), .rf_wdata_o(rf_wdata_o),
        .fwd_valid_o(fwd_valid_o), .fwd_dest_o(fwd_dest_o), .fwd_data_o(fwd_data_o),
        .ll_count_o(ll_count_o), .debug_wb_have_inst(debug_wb_have_inst),
        .debug_wb_pc(debug_wb_pc), .debug_wb_ena(debug_wb_ena),
        .debug_wb_reg(debug_wb_reg), .debug_wb_value(debug_wb_value)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic we, input logic [4:0] dest,
                             input logic [31:0] data, input logic [31:0] pc);
        m_valid_i = v;  m_mem_load_i = 1'b0; m_load_word_i = 32'h0;
        m_load_size_i = 2'b10; m_load_unsigned_i = 1'b0; m_addr_lo_i = 2'b00;
        m_alu_result_i = data; m_rf_we_i = we; m_rf_dest_i = dest; m_pc_i = pc;
    endtask

    task automatic drive_load(input logic [1:0] size, input logic uns, input logic [1:0] lo,
                              input logic [4:0] dest);
        m_valid_i = 1'b1; m_mem_load_i = 1'b1; m_load_word_i = 32'h80F1_7F22;
        m_load_size_i = size; m_load_unsigned_i = uns; m_addr_lo_i = lo;
        m_alu_result_i = 32'h1234_5678; m_rf_we_i = 1'b1; m_rf_dest_i = dest;
        m_pc_i = 32'h200 + 32'(dest);
    endtask

    task automatic drive_ll(input logic v, input logic [4:0] dest, input logic [31:0] res,
                            input logic [31:0] pc);
        ll_valid_i = v; ll_rf_dest_i = dest; ll_result_i = res; ll_pc_i = pc;
    endtask

    task automatic chk_wb(input string tag, input logic we, input logic [4:0] dest,
                          input logic [31:0] data);
        check({tag, ".we"},   64'(rf_we_o),    64'(we));
        check({tag, ".dest"}, 64'(rf_dest_o),  64'(dest));
        check({tag, ".data"}, 64'(rf_wdata_o), 64'(data));
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".we"},   64'(rf_we_o),            64'd0);
        check({tag, ".have"}, 64'(debug_wb_have_inst), 64'd0);
        check({tag, ".data"}, 64'(rf_wdata_o),         64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush_writeback = 1'b0;
        drive_alu(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        drive_ll(1'b0, 5'd0, 32'h0, 32'h0);
        cyc();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst.m_ready",  64'(m_ready_o),    64'd1);
        check("rst.ll_ready", 64'(ll_ready_o),   64'd1);
        check("rst.count",    64'(ll_count_o),   64'd0);
        check("rst.fwd",      64'(fwd_valid_o),  64'd0);
        check("rst.ena",      64'(debug_wb_ena), 64'd0);
        check("rst.dest",     64'(rf_dest_o),    64'd0);
        check("rst.pc",       64'(debug_wb_pc),  64'd0);
        chk_idle("rst");
        cyc();

        // Back-to-back ALU writes x5, x6, x7
        drive_alu(1'b1, 1'b1, 5'd5, 32'h1111_0005, 32'h100);
        @(negedge clk); check("b2b0.m_ready", 64'(m_ready_o), 64'd1); chk_idle("b2b0");
        cyc();
        drive_alu(1'b1, 1'b1, 5'd6, 32'h1111_0006, 32'h104);
        @(negedge clk); chk_wb("b2b.x5", 1'b1, 5'd5, 32'h1111_0005);
        check("b2b.x5.pc", 64'(debug_wb_pc), 64'h100);
        check("b2b.x5.m_ready", 64'(m_ready_o), 64'd1);
        cyc();
        drive_alu(1'b1, 1'b1, 5'd7, 32'h1111_0007, 32'h108);
        @(negedge clk); chk_wb("b2b.x6", 1'b1, 5'd6, 32'h1111_0006);
        check("b2b.x6.m_ready", 64'(m_ready_o), 64'd1);
        cyc();
        drive_alu(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk); chk_wb("b2b.x7", 1'b1, 5'd7, 32'h1111_0007);
        check("b2b.x7.fwd", 64'(fwd_data_o), 64'h1111_0007);
        cyc();
        @(negedge clk); chk_idle("b2b.end");
        cyc();

        // Load alignment on word 0x80F1_7F22
        drive_load(2'b00, 1'b0, 2'd3, 5'd8);
        cyc();
        drive_load(2'b01, 1'b1, 2'd2, 5'd9);
        @(negedge clk); chk_wb("ld.b3s", 1'b1, 5'd8, 32'hFFFF_FF80);
        cyc();
        drive_load(2'b00, 1'b0, 2'd1, 5'd10);
        @(negedge clk); chk_wb("ld.h2u", 1'b1, 5'd9, 32'h0000_80F1);
        cyc();
        drive_load(2'b11, 1'b0, 2'd0, 5'd11);
        @(negedge clk); chk_wb("ld.b1", 1'b1, 5'd10, 32'h0000_007F);
        cyc();
        drive_load(2'b01, 1'b0, 2'd3, 5'd12);
        @(negedge clk); chk_wb("ld.sz11", 1'b1, 5'd11, 32'h80F1_7F22);
        cyc();
        drive_alu(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk); chk_wb("ld.h3s", 1'b1, 5'd12, 32'hFFFF_80F1);
        cyc();

        // Queue fills while the pipeline stays valid
        drive_alu(1'b1, 1'b1, 5'd10, 32'hA000_0001, 32'h300);
        drive_ll(1'b1, 5'd20, 32'hB000_0001, 32'h400);
        @(negedge clk); chk_idle("ll.c0");
        cyc();
        drive_alu(1'b1, 1'b1, 5'd11, 32'hA000_0002, 32'h304);
        drive_ll(1'b1, 5'd21, 32'hB000_0002, 32'h404);
        @(negedge clk); chk_wb("ll.c1.P1", 1'b1, 5'd10, 32'hA000_0001);
        check("ll.c1.count", 64'(ll_count_o), 64'd1);
        cyc();
        drive_alu(1'b1, 1'b1, 5'd12, 32'hA000_0003, 32'h308);
        drive_ll(1'b1, 5'd22, 32'hB000_0003, 32'h408);
        @(negedge clk); chk_wb("ll.c2.L1", 1'b1, 5'd20, 32'hB000_0001);
        check("ll.c2.count",    64'(ll_count_o),  64'd2);
        check("ll.c2.ll_ready", 64'(ll_ready_o),  64'd0);
        check("ll.c2.m_ready",  64'(m_ready_o),   64'd0);
        check("ll.c2.pc",       64'(debug_wb_pc), 64'h400);
        cyc();
        drive_ll(1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk); chk_wb("ll.c3.P2", 1'b1, 5'd11, 32'hA000_0002);
        check("ll.c3.count", 64'(ll_count_o), 64'd1);
        check("ll.c3.m_ready", 64'(m_ready_o), 64'd1);
        cyc();
        drive_alu(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk); chk_wb("ll.c4.P3", 1'b1, 5'd12, 32'hA000_0003);
        cyc();
        @(negedge clk); chk_wb("ll.c5.L2", 1'b1, 5'd21, 32'hB000_0002);
        cyc();
        @(negedge clk); chk_idle("ll.c6");
        check("ll.c6.count", 64'(ll_count_o), 64'd0);
        cyc();

        // x0 destination and rf_we=0 entries
        drive_alu(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h500);
        cyc();
        drive_alu(1'b1, 1'b0, 5'd9, 32'h0000_0999, 32'h504);
        @(negedge clk);
        check("x0.we",   64'(rf_we_o),            64'd0);
        check("x0.fwd",  64'(fwd_valid_o),        64'd0);
        check("x0.have", 64'(debug_wb_have_inst), 64'd1);
        check("x0.ena",  64'(debug_wb_ena),       64'd0);
        cyc();
        drive_alu(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("nowe.we",   64'(rf_we_o),            64'd0);
        check("nowe.have", 64'(debug_wb_have_inst), 64'd1);
        check("nowe.reg",  64'(debug_wb_reg),       64'd9);
        check("nowe.pc",   64'(debug_wb_pc),        64'h504);
        cyc();

        // Flush with S valid and one queued entry
        drive_alu(1'b1, 1'b1, 5'd13, 32'hC000_0013, 32'h600);
        drive_ll(1'b1, 5'd23, 32'hD000_0023, 32'h700);
        cyc();
        drive_alu(1'b1, 1'b1, 5'd14, 32'hC000_0014, 32'h604);
        drive_ll(1'b0, 5'd0, 32'h0, 32'h0);
        flush_writeback = 1'b1;
        @(negedge clk); chk_wb("fl.c1.S", 1'b1, 5'd13, 32'hC000_0013);
        check("fl.c1.count", 64'(ll_count_o), 64'd1);
        cyc();
        flush_writeback = 1'b0;
        drive_alu(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk); chk_wb("fl.c2.Q", 1'b1, 5'd23, 32'hD000_0023);
        cyc();
        @(negedge clk); chk_idle("fl.c3");
        cyc();

        // Reset mid-stream with the queue full
        drive_alu(1'b1, 1'b1, 5'd15, 32'hE000_0015, 32'h800);
        drive_ll(1'b1, 5'd24, 32'hF000_0024, 32'h900);
        cyc();
        drive_alu(1'b1, 1'b1, 5'd16, 32'hE000_0016, 32'h804);
        drive_ll(1'b1, 5'd25, 32'hF000_0025, 32'h904);
        cyc();
        reset = 1'b1;
        @(negedge clk); check("rs.pre.count", 64'(ll_count_o), 64'd2);
        cyc();
        reset = 1'b0;
        drive_alu(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        drive_ll(1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("rs.count",    64'(ll_count_o), 64'd0);
        check("rs.m_ready",  64'(m_ready_o),  64'd1);
        check("rs.ll_ready", 64'(ll_ready_o), 64'd1);
        chk_idle("rs");
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
